// File: rtl/mma_tile_seq_pkg.sv
// Shared types and constants for the 4x4 MMA tile sequencer: FSM states,
// default widths, datapath latency bounds and {row,col} index field widths.
package mma_tile_seq_pkg;

   localparam int DEF_DWIDTH  = 16;
   localparam int DEF_AWIDTH  = 92;
   localparam int MMA_LAT_MIN = 1;
   localparam int MMA_LAT_MAX = 8;

   localparam int ROW_W  = 2;
   localparam int COL_W  = 2;
   localparam int IDX_W  = ROW_W + COL_W;
   localparam int N_ELEM = 1 << IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } seq_state_t;

   function automatic logic [IDX_W-1:0] elem_idx(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/mma_acc_buf.sv
// 16-entry accumulator buffer, one entry per C element: one write port and two
// asynchronous read ports (C operand read and drain read).
module mma_acc_buf
   import mma_tile_seq_pkg::*;
#(
   parameter int AWIDTH = DEF_AWIDTH
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [AWIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]  c_raddr,
   output logic [AWIDTH-1:0] c_rdata,
   input  logic [IDX_W-1:0]  d_raddr,
   output logic [AWIDTH-1:0] d_rdata
);

   // Contents are never reset: every entry is rewritten at kt=0 before it is read.
   logic [AWIDTH-1:0] mem [N_ELEM];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign c_rdata = mem[c_raddr];
   assign d_rdata = mem[d_raddr];

endmodule

// File: rtl/mma_tile_seq.sv
// 4x4 MMA tile sequencer: issues (kt,i,j) dot products, accumulates results in
// a 16-entry buffer, then drains them. Optional macro MMA_TILE_SEQ_CINIT_EN
// seeds kt=0 accumulators from c_init instead of zero.
module mma_tile_seq
   import mma_tile_seq_pkg::*;
#(
   parameter int DWIDTH  = DEF_DWIDTH,
   parameter int AWIDTH  = DEF_AWIDTH,
   parameter int MMA_LAT = 2,
   parameter int KTW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [KTW-1:0]    job_ktiles,
   output logic              iss_valid,
   input  logic              iss_ready,
   output logic [1:0]        iss_row,
   output logic [1:0]        iss_col,
   output logic [KTW-1:0]    iss_kt,
   output logic [AWIDTH-1:0] mma_c_in,
   input  logic [AWIDTH-1:0] mma_c_out,
   input  logic [AWIDTH-1:0] c_init,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [3:0]        res_idx,
   output logic [AWIDTH-1:0] res_data,
   output logic              busy
);

   seq_state_t state_reg, state_next;

   logic [KTW-1:0]   ktiles_reg;
   logic [KTW-1:0]   kt_reg;
   logic [ROW_W-1:0] row_reg;
   logic [COL_W-1:0] col_reg;
   logic [IDX_W-1:0] res_idx_reg;

   logic             pipe_vld_reg [MMA_LAT];
   logic [IDX_W-1:0] pipe_idx_reg [MMA_LAT];

   logic iss_fire, res_fire, last_issue, pipe_body_busy;
   logic [AWIDTH-1:0] c_rdata, d_rdata;

   logic [DWIDTH-1:0] unused_dwidth;
   logic              unused_c_init;
   assign unused_dwidth = '0;
   assign unused_c_init = ^c_init;

   assign iss_fire   = (state_reg == ST_ISSUE) && iss_ready;
   assign res_fire   = (state_reg == ST_DRAIN) && res_ready;
   assign last_issue = (kt_reg == ktiles_reg - KTW'(1)) && (row_reg == '1) && (col_reg == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      job_ready  = 1'b0;
      iss_valid  = 1'b0;
      res_valid  = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            job_ready = 1'b1;
            busy      = 1'b0;
            if (job_valid) state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            iss_valid = 1'b1;
            if (iss_fire && last_issue) state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            // Leave as the tail writes back, so DRAIN starts with the pipe empty.
            if (!pipe_body_busy) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            res_valid = 1'b1;
            if (res_fire && (res_idx_reg == '1)) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ktiles_reg  <= '0;
         kt_reg      <= '0;
         row_reg     <= '0;
         col_reg     <= '0;
         res_idx_reg <= '0;
      end else begin
         if ((state_reg == ST_IDLE) && job_valid) begin
            ktiles_reg  <= (job_ktiles == '0) ? KTW'(1) : job_ktiles;
            kt_reg      <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            res_idx_reg <= '0;
         end
         if (iss_fire) begin
            col_reg <= col_reg + COL_W'(1);
            if (col_reg == '1) begin
               row_reg <= row_reg + ROW_W'(1);
               if (row_reg == '1) begin
                  kt_reg <= last_issue ? '0 : kt_reg + KTW'(1);
               end
            end
         end
         if (res_fire) begin
            res_idx_reg <= res_idx_reg + IDX_W'(1);
         end
      end
   end

   // Valid/index shadow of the datapath; the tail marks where mma_c_out lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < MMA_LAT; s++) begin
            pipe_vld_reg[s] <= 1'b0;
            pipe_idx_reg[s] <= '0;
         end
      end else begin
         pipe_vld_reg[0] <= iss_fire;
         pipe_idx_reg[0] <= elem_idx(row_reg, col_reg);
         for (int s = 1; s < MMA_LAT; s++) begin
            pipe_vld_reg[s] <= pipe_vld_reg[s-1];
            pipe_idx_reg[s] <= pipe_idx_reg[s-1];
         end
      end
   end

   always_comb begin
      pipe_body_busy = 1'b0;
      for (int s = 0; s < MMA_LAT - 1; s++) begin
         pipe_body_busy = pipe_body_busy | pipe_vld_reg[s];
      end
   end

   mma_acc_buf #(
      .AWIDTH (AWIDTH)
   ) u_acc_buf (
      .clk     (clk),
      .we      (pipe_vld_reg[MMA_LAT-1]),
      .waddr   (pipe_idx_reg[MMA_LAT-1]),
      .wdata   (mma_c_out),
      .c_raddr (elem_idx(row_reg, col_reg)),
      .c_rdata (c_rdata),
      .d_raddr (res_idx_reg),
      .d_rdata (d_rdata)
   );

   always_comb begin
      mma_c_in = c_rdata;
      if (kt_reg == '0) begin
`ifdef MMA_TILE_SEQ_CINIT_EN
         mma_c_in = c_init;
`else
         mma_c_in = '0;
`endif
      end
   end

   assign iss_row  = row_reg;
   assign iss_col  = col_reg;
   assign iss_kt   = kt_reg;
   assign res_idx  = res_idx_reg;
   assign res_data = d_rdata;

endmodule

// File: doc/mma_tile_seq.md
MMA_TILE_SEQ -- requirements
Module: mma_tile_seq

Interface
REQ-001 SHALL have parameters: DWIDTH, default 16, operand element width; AWIDTH, default 92, Kulisch accumulator width; MMA_LAT, default 2, dot-product datapath latency in cycles (legal range 1..8); KTW, default 4, width of the K-tile count.
REQ-002 SHALL have ports, clock and reset first:
- clk, in, 1, single clock, all state on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- job_valid, in, 1, job request.
- job_ready, out, 1, sequencer idle and accepting a job.
- job_ktiles, in, KTW, number of K-tiles to accumulate (0 is treated as 1).
- iss_valid, out, 1, a dot-product issue is presented.
- iss_ready, in, 1, operand source has the A row / B column for this index.
- iss_row, out, 2, output row i.
- iss_col, out, 2, output column j.
- iss_kt, out, KTW, current K-tile.
- mma_c_in, out, AWIDTH, accumulator value driven into the datapath C input.
- mma_c_out, in, AWIDTH, datapath result, valid MMA_LAT cycles after the issue handshake.
- c_init, in, AWIDTH, per-element initial accumulator (used only under REQ-019).
- res_valid, out, 1, result element presented.
- res_ready, in, 1, result consumer accepts.
- res_idx, out, 4, element index {row,col}.
- res_data, out, AWIDTH, accumulated element.
- busy, out, 1, high from job accept until the last result handshake.

Function
REQ-003 SHALL hold a 16-entry x AWIDTH accumulator buffer, one entry per C element, indexed {row,col}.
REQ-004 SHALL implement the FSM IDLE -> ISSUE -> FLUSH -> DRAIN -> IDLE.
REQ-005 IDLE: job_ready=1; job_valid&job_ready latches the K-tile count, clears the counters, and moves to ISSUE.
REQ-006 ISSUE: iss_valid=1; an issue fires on iss_valid&iss_ready; iss_valid and the index outputs stay stable while iss_ready=0.
REQ-007 Issue order SHALL be K-tile outer, row middle, column inner: (kt,i,j) = (0,0,0),(0,0,1)..(0,3,3),(1,0,0)...
REQ-008 mma_c_in SHALL be combinational on the current index: 0 when kt=0, otherwise buffer[{i,j}].
REQ-009 SHALL carry a valid/index shift pipeline of depth MMA_LAT; when the pipe tail is valid, mma_c_out SHALL be written to buffer[tail index].
REQ-010 After the final issue (kt=ktiles-1, i=3, j=3), the FSM SHALL go to FLUSH.
REQ-011 FLUSH SHALL move to DRAIN once the pipe is empty: exactly MMA_LAT cycles after the final issue.
REQ-012 No read-after-write hazard exists, because revisits are 16 issues apart and 16 > MMA_LAT; MMA_LAT > 15 is illegal.
REQ-013 DRAIN: res_valid=1 with res_idx counting 0..15; res_data=buffer[res_idx]; the index advances only on res_valid&res_ready; idx and data stay stable under backpressure.
REQ-014 After the handshake at res_idx=15, the FSM SHALL return to IDLE in the next cycle; a new job can be accepted that cycle.
REQ-015 job_valid outside IDLE SHALL be ignored (job_ready=0); busy = (state != IDLE).
REQ-016 Every job SHALL complete with exactly 16*ktiles issue handshakes and 16 result handshakes.

Reset
REQ-017 rst high SHALL asynchronously force the IDLE state with job_ready=1 and busy=iss_valid=res_valid=0; all counters, the pipe valid bits and the index outputs SHALL be 0.
REQ-018 Assertion of rst mid-job SHALL abandon the job; results still in the pipe are discarded; buffer contents need not be reset (they are overwritten before being read).

Configuration
REQ-019 Macro MMA_TILE_SEQ_CINIT_EN:
- Defined: for kt=0, mma_c_in = c_init, sampled on the issue handshake.
- Undefined: c_init is ignored and kt=0 uses 0.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, the default AWIDTH/DWIDTH, the MMA_LAT bound, and the index field widths.
REQ-021 The accumulator buffer SHALL be one sub-module, mma_acc_buf: 16 x AWIDTH, 1 write port and 2 asynchronous read ports (C read and drain read).

Verification
REQ-022 ktiles=1, MMA_LAT=2, stub dot product returning c_in+{i,j}+1 -> results 1..16 at idx 0..15; res_valid asserts 2 cycles after the 16th issue.
REQ-023 ktiles=3, same stub -> each element returns 3*({i,j}+1); 48 issue handshakes in (kt,i,j) order.
REQ-024 iss_ready toggling 1/0 and res_ready held low 5 cycles at idx 7 -> indices and data stay stable while stalled; final results equal those of REQ-022.
REQ-025 rst pulsed at issue 9 of a ktiles=2 job -> next cycle IDLE with job_ready=1; a new ktiles=1 job gives exactly REQ-022 results.
REQ-026 With MMA_TILE_SEQ_CINIT_EN defined and c_init=100 -> ktiles=1 results are 101..116; without the macro they are 1..16.
REQ-027 job_ktiles=0 -> behaves as ktiles=1; job_valid held high during DRAIN -> second job accepted only in the cycle after the res_idx=15 handshake.
